axil_reg_bank: RTL

//  AXI4-Lite slave endpoint on the axi interface bus: the consumer sitting directly downstream of an
//  axi.master port. Decodes AW/W/AR traffic into a bank of NUM_REGS 32-bit control/status registers

---
 rtl/axil_reg_bank.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axil_reg_bank.sv
// axil_reg_bank: AXI4-Lite slave mapping NUM_REGS 32-bit registers with byte-strobe writes,
// per-register write pulses and OKAY/SLVERR responses; one outstanding transaction per direction.
//
// state      | meaning
// WR_IDLE    | collecting AW and W, in either order or together
// WR_COMMIT  | both captured; register byte update and write pulse this cycle
// WR_RESP    | write response held until bready
// RD_IDLE    | waiting for AR
// RD_RESP    | read data and response held until rready
module axil_reg_bank #(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter int          NUM_REGS    = 16,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [ADDR_WIDTH-1:0]  s_awaddr,
  input  logic [2:0]             s_awprot,
  input  logic                   s_awvalid,
  output logic                   s_awready,
  input  logic [31:0]            s_wdata,
  input  logic [3:0]             s_wstrb,
  input  logic                   s_wvalid,
  output logic                   s_wready,
  output logic [1:0]             s_bresp,
  output logic                   s_bvalid,
  input  logic                   s_bready,
  input  logic [ADDR_WIDTH-1:0]  s_araddr,
  input  logic [2:0]             s_arprot,
  input  logic                   s_arvalid,
  output logic                   s_arready,
  output logic [31:0]            s_rdata,
  output logic [1:0]             s_rresp,
  output logic                   s_rvalid,
  input  logic                   s_rready,
  output logic [NUM_REGS*32-1:0] regs_o,
  output logic [NUM_REGS-1:0]    wr_pulse_o
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $fatal(1, "axil_reg_bank: DATA_WIDTH must be 32");
  end
  if (NUM_REGS < 1 || NUM_REGS > 256) begin : g_bad_num_regs
    $fatal(1, "axil_reg_bank: NUM_REGS must be in 1..256");
  end
  if (ADDR_WIDTH < IDX_W + 2) begin : g_bad_addr_width
    $fatal(1, "axil_reg_bank: ADDR_WIDTH too small for NUM_REGS");
  end

  typedef enum logic [1:0] {WR_IDLE, WR_COMMIT, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

  wr_state_e             wr_state_q, wr_state_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  aw_got_q, aw_got_d;
  logic                  w_got_q, w_got_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [31:0]           regs_q [NUM_REGS];
  logic [31:0]           regs_d [NUM_REGS];

  rd_state_e             rd_state_q, rd_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic                  aw_hs, w_hs, ar_hs;
  logic                  wr_in_range, rd_in_range, wr_commit;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic                  unused_prot;

  assign unused_prot = ^{s_awprot, s_arprot};

  assign aw_hs = awready_q & s_awvalid;
  assign w_hs  = wready_q & s_wvalid;
  assign ar_hs = arready_q & s_arvalid;

  assign wr_in_range = (awaddr_q >> 2) < NUM_REGS_A;
  assign wr_idx      = awaddr_q[2 +: IDX_W];
  assign wr_commit   = (wr_state_q == WR_COMMIT) && wr_in_range;
  assign rd_in_range = (s_araddr >> 2) < NUM_REGS_A;
  assign rd_idx      = s_araddr[2 +: IDX_W];

  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          awaddr_d = s_awaddr;
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = s_wdata;
          wstrb_d = s_wstrb;
        end
        // Readies are registered so each one falls the cycle after its own handshake.
        if (aw_got_d && w_got_d) begin
          wr_state_d = WR_COMMIT;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
        end else begin
          awready_d = !aw_got_d;
          wready_d  = !w_got_d;
        end
      end
      WR_COMMIT: begin
        aw_got_d   = 1'b0;
        w_got_d    = 1'b0;
        bvalid_d   = 1'b1;
        bresp_d    = wr_in_range ? RESP_OKAY : RESP_SLVERR;
        wr_state_d = WR_RESP;
      end
      WR_RESP: begin
        if (s_bready) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) regs_d[r] = regs_q[r];
    if (wr_commit) begin
      for (int k = 0; k < 4; k++) begin
        if (wstrb_q[k]) regs_d[wr_idx][8*k +: 8] = wdata_q[8*k +: 8];
      end
    end
  end

  // A zero-strobe write still counts as a committed write and pulses.
  always_comb begin
    wr_pulse_o = '0;
    if (wr_commit) wr_pulse_o[wr_idx] = 1'b1;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      RD_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rdata_d    = rd_in_range ? regs_q[rd_idx] : 32'h0;
          rresp_d    = rd_in_range ? RESP_OKAY : RESP_SLVERR;
          rd_state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        if (s_rready) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_state_q <= WR_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= RESET_VALUE;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_out
    assign regs_o[32*i +: 32] = regs_q[i];
  end

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;

endmodule
